// File: rtl/fft8_input_loader.sv
// rtl/fft8_input_loader.sv - serial-to-parallel ping-pong frame loader ahead of the 8-point FFT core
module fft8_input_loader #(
   parameter int W      = 16,
   parameter int N      = 8,
   parameter bit BITREV = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [W-1:0] x_re [0:N-1],
   output logic [W-1:0] x_im [0:N-1],
   output logic         out_valid,
   input  logic         out_ready,
   output logic         sync_err
);

   // Two banks of N complex samples; one fills while the other is presented.
   logic [W-1:0] bank_re [0:1][0:N-1];
   logic [W-1:0] bank_im [0:1][0:N-1];

   logic [1:0] full;
   logic [1:0] full_next;
   logic       wr_bank;
   logic       rd_bank;
   logic [2:0] wr_cnt;
   logic [2:0] slot;
   logic       accept;
   logic       frame_done;
   logic       release_frame;

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];

   // Handshake decode and write-slot selection (bit-reversed for the DIT core).
   always_comb begin
      accept        = in_valid && in_ready;
      frame_done    = accept && (wr_cnt == 3'd7);
      release_frame = out_valid && out_ready;
      slot          = BITREV ? {wr_cnt[0], wr_cnt[1], wr_cnt[2]} : wr_cnt;
   end

   // Fill-complete and release may land on different banks in the same cycle.
   always_comb begin
      full_next = full;
      if (frame_done) begin
         full_next[wr_bank] = 1'b1;
      end
      if (release_frame) begin
         full_next[rd_bank] = 1'b0;
      end
   end

   // Sample storage: write the accepted beat into its slot of the filling bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N; k++) begin
               bank_re[b][k] <= '0;
               bank_im[b][k] <= '0;
            end
         end
      end else if (accept) begin
         bank_re[wr_bank][slot] <= in_re;
         bank_im[wr_bank][slot] <= in_im;
      end
   end

   // Bank pointers, beat counter, full flags and the framing-error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_cnt   <= 3'd0;
         sync_err <= 1'b0;
      end else begin
         full     <= full_next;
         sync_err <= 1'b0;
         if (release_frame) begin
            rd_bank <= !rd_bank;
         end
         if (accept) begin
            if (wr_cnt == 3'd7) begin
               // Eighth beat always closes the frame; a missing in_last is flagged.
               wr_cnt   <= 3'd0;
               wr_bank  <= !wr_bank;
               sync_err <= !in_last;
            end else if (in_last) begin
               // Early in_last: drop the partial frame and restart at slot 0.
               wr_cnt   <= 3'd0;
               sync_err <= 1'b1;
            end else begin
               wr_cnt <= wr_cnt + 3'd1;
            end
         end
      end
   end

   // Present the read bank; it cannot change until the consumer releases it.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         x_re[k] = bank_re[rd_bank][k];
         x_im[k] = bank_im[rd_bank][k];
      end
   end

endmodule

// File: tb/tb_fft8_input_loader.sv
// tb/tb_fft8_input_loader.sv - scoreboard bench for fft8_input_loader (bit-reversed and natural order)
module tb_fft8_input_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_re, in_im;
   logic        in_valid, in_last, out_ready;

   logic        in_ready, out_valid, sync_err;
   logic [15:0] x_re [0:7];
   logic [15:0] x_im [0:7];
   logic        in_ready0, out_valid0, sync_err0;
   logic [15:0] x_re0 [0:7];
   logic [15:0] x_im0 [0:7];

   int total = 0;
   int bad   = 0;

   // Model state: frames in natural sample order, packed sample n at [n*16 +: 16].
   logic [127:0] q_re [$];
   logic [127:0] q_im [$];
   logic [127:0] cur_re, cur_im;
   int  cnt        = 0;
   logic exp_sync  = 1'b0;
   int  acc_count  = 0;
   int  frames_out = 0;
   int  sync_seen  = 0;
   int  ready_low  = 0;

   logic [15:0] ef [0:7] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
   logic [15:0] en [0:7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
   int base_a, base_f, base_s, base_r;

   fft8_input_loader #(.W(16), .N(8), .BITREV(1'b1)) dut (
      .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .x_re(x_re), .x_im(x_im),
      .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
   );

   fft8_input_loader #(.W(16), .N(8), .BITREV(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready0), .x_re(x_re0), .x_im(x_im0),
      .out_valid(out_valid0), .out_ready(out_ready), .sync_err(sync_err0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [127:0] pack8(input logic [15:0] a [0:7]);
      logic [127:0] p;
      for (int k = 0; k < 8; k++) p[k*16 +: 16] = a[k];
      return p;
   endfunction

   // Slot k of the bit-reversed frame holds sample bitrev3(k).
   function automatic logic [127:0] rev_pack(input logic [127:0] nat);
      logic [127:0] p;
      logic [2:0]   k3;
      int           r;
      for (int k = 0; k < 8; k++) begin
         k3 = 3'(k);
         r  = (k3[0] ? 4 : 0) + (k3[1] ? 2 : 0) + (k3[2] ? 1 : 0);
         p[k*16 +: 16] = nat[r*16 +: 16];
      end
      return p;
   endfunction

   // Scoreboard: check the presented frame and flags each cycle, then apply this cycle's handshakes.
   always @(negedge clk) begin
      if (rst) begin
         q_re.delete();
         q_im.delete();
         cnt      = 0;
         exp_sync = 1'b0;
      end else begin
         chk("sync_err", sync_err, exp_sync);
         chk("sync_err_nat", sync_err0, exp_sync);
         chk("out_valid", out_valid, q_re.size() != 0);
         chk("out_valid_nat", out_valid0, q_re.size() != 0);
         chk("in_ready", in_ready, q_re.size() < 2);
         chk("in_ready_nat", in_ready0, q_re.size() < 2);
         if (sync_err) sync_seen++;
         if (in_valid && !in_ready) ready_low++;
         if (q_re.size() != 0) begin
            chk("x_re_rev", pack8(x_re), rev_pack(q_re[0]));
            chk("x_im_rev", pack8(x_im), rev_pack(q_im[0]));
            chk("x_re_nat", pack8(x_re0), q_re[0]);
            chk("x_im_nat", pack8(x_im0), q_im[0]);
            if (out_ready) begin
               void'(q_re.pop_front());
               void'(q_im.pop_front());
               frames_out++;
            end
         end
         exp_sync = 1'b0;
         if (in_valid && in_ready) begin
            acc_count++;
            cur_re[cnt*16 +: 16] = in_re;
            cur_im[cnt*16 +: 16] = in_im;
            if (cnt == 7) begin
               q_re.push_back(cur_re);
               q_im.push_back(cur_im);
               exp_sync = !in_last;
               cnt      = 0;
            end else if (in_last) begin
               exp_sync = 1'b1;
               cnt      = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded wait).
   task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input logic last);
      int waited = 0;
      in_valid = 1'b1;
      in_re    = re;
      in_im    = im;
      in_last  = last;
      while (!in_ready && waited < 200) begin
         tick(1);
         waited++;
      end
      if (!in_ready) chk("beat_timeout", in_ready, 1'b1);
      tick(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_x_re", pack8(x_re), 128'd0);
      chk("rst_x_im", pack8(x_im), 128'd0);
      chk("rst_sync_err", sync_err, 1'b0);
      tick(1);

      // Ramp frame: known bit-reversed and natural layouts one cycle after the last accept.
      for (int i = 0; i < 8; i++) send_beat(16'(i), 16'd0, i == 7);
      @(negedge clk);
      chk("ramp_valid", out_valid, 1'b1);
      chk("ramp_rev", pack8(x_re), pack8(ef));
      chk("ramp_nat", pack8(x_re0), pack8(en));
      tick(3);

      // Back-pressure: 24 beats with the consumer stalled, then released.
      out_ready = 1'b0;
      base_a = acc_count;
      fork
         begin
            for (int i = 0; i < 24; i++) send_beat(16'(100 + i), 16'($urandom), (i % 8) == 7);
         end
         begin
            tick(40);
            chk("held_accepts", 32'(acc_count - base_a), 32'd16);
            base_f = frames_out;
            out_ready = 1'b1;
         end
      join
      tick(4);
      chk("held_frames", 32'(frames_out - base_f), 32'd3);

      // Early in_last on beat 5, then a clean frame.
      base_s = sync_seen; base_f = frames_out;
      for (int i = 0; i < 5; i++) send_beat(16'($urandom), 16'($urandom), i == 4);
      tick(3);
      chk("early_last_sync", 32'(sync_seen - base_s), 32'd1);
      chk("early_last_frames", 32'(frames_out - base_f), 32'd0);
      for (int i = 0; i < 8; i++) send_beat(16'($urandom), 16'($urandom), i == 7);
      tick(3);
      chk("clean_after_err", 32'(frames_out - base_f), 32'd1);

      // Sustained stream of 64 beats with the consumer always ready.
      base_f = frames_out; base_r = ready_low;
      for (int i = 0; i < 64; i++) send_beat(16'($urandom), 16'($urandom), (i % 8) == 7);
      tick(3);
      chk("stream_frames", 32'(frames_out - base_f), 32'd8);
      chk("stream_ready_low", 32'(ready_low - base_r), 32'd0);

      // Reset mid-frame, then a full frame.
      for (int i = 0; i < 4; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      tick(1);
      base_f = frames_out;
      for (int i = 0; i < 8; i++) send_beat(16'($urandom), 16'($urandom), i == 7);
      tick(3);
      chk("midrst_frame", 32'(frames_out - base_f), 32'd1);

      // Eighth beat without in_last: frame still emitted, error flagged.
      base_f = frames_out; base_s = sync_seen;
      for (int i = 0; i < 8; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
      tick(3);
      chk("nolast_frame", 32'(frames_out - base_f), 32'd1);
      chk("nolast_sync", 32'(sync_seen - base_s), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
